mdio_responder: RTL and testbench
=================================

# mdio_responder

Clause-22 MDIO management responder (PHY side) for the GbE readout path, complementing the existing MDIO initiator. It decodes MDC/MDIO frames oversampled in the 125 MHz system clock domain, holds a small bank of 16-bit control/status registers, and answers read frames by driving MDIO through a tristate pair. It lets custom logic behind the PCS/PMA (bridge FIFOs, link counters) be configured over the same management bus as the PCS/PMA cores.

## Interface
- NUM_REGS, 16, number of implemented registers (1..32), addresses 0..NUM_REGS-1
- PRE_MIN, 32, consecutive preamble ones required before ST (1..32)

- clk  in  1  system clock (125 MHz, usrclk); MDC must be ≤ clk/8
- rst  in  1  synchronous, active-high reset
- phyaddr  in  5  responder PHY address, static
- mdc  in  1  management clock from initiator, asynchronous to clk
- mdio_i  in  1  MDIO line input, asynchronous to clk
- mdio_o  out  1  MDIO drive value
- mdio_t  out  1  tristate control, 1 = released (high-Z)
- regs  out  16*NUM_REGS  register bank, reg n at [16n+15:16n]
- wr_stb  out  1  one-cycle pulse on completed matching write frame
- wr_addr  out  5  register address of last write, valid with wr_stb
- wr_data  out  16  data of last write, valid with wr_stb
- rd_stb  out  1  one-cycle pulse when a matching read is accepted
- frame_err  out  1  one-cycle pulse on aborted frame

## Operation
- mdc, mdio_i pass through 2-FF synchronizers; a third mdc flop gives rise detect. All decoding happens on detected MDC rising edges ("edges"); synchronized mdio sampled at each edge.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, DATA.
- IDLE: 6-bit ones counter, saturates at 32; sampled 1 increments; sampled 0 with count ≥ PRE_MIN -> ST (this 0 is ST bit 1), else count cleared.
- ST: sample must be 1 -> OP; else frame_err, IDLE.
- OP: 2 bits MSB first; 01 = write, 10 = read; 00/11 -> frame_err, IDLE.
- PHYAD: 5 bits MSB first; REGAD: 5 bits MSB first. Match = PHYAD == phyaddr.
- At edge sampling last REGAD bit: if read & match, snapshot regs[REGAD] (0x0000 if REGAD ≥ NUM_REGS) into 16-bit shift register, pulse rd_stb.
- TA, read match: edge of TA bit 1 -> mdio_t=0, mdio_o=0; edge of TA bit 2 -> mdio_o=data[15].
- TA, write: bits sampled, must be 1 then 0; otherwise frame_err, IDLE, no write.
- DATA (16 bits): read match: each edge shifts next bit out; edge of bit 0 -> mdio_t=1, IDLE. Write: shift in MSB first; at 16th bit, if match: wr_stb pulse, wr_addr/wr_data updated, regs[REGAD] written if REGAD < NUM_REGS (ignored otherwise, wr_stb still pulses).
- No match: frame tracked through DATA without driving or writing, then IDLE.
- Ones counter cleared on every return to IDLE; a new frame always needs a fresh preamble of PRE_MIN ones.
- Width rules: bit counter 4 bits; regs fully writable, no read-only or self-clearing bits.

## Timing
- Reset values: mdio_o=1, mdio_t=1, regs=0, wr_stb=0, wr_addr=0, wr_data=0, rd_stb=0, frame_err=0, state IDLE, counters 0.
- Edge detect latency: 3 clk from mdc pin rise; outputs (mdio_o/t, strobes) registered, change 1 clk after detect, i.e. ≤ 4 clk (32 ns) after MDC rise, well inside the 300 ns clause-22 output window.
- regs update in same cycle as wr_stb.
- Read snapshot is taken before TA; a write from another source cannot exist (single initiator), so read data is stable for whole DATA phase.
- Reset mid-frame: next cycle mdio_t=1, state IDLE, regs cleared, no strobes.
- Strobes are exclusive per frame; at most one of wr_stb/rd_stb/frame_err per frame.

## Test plan
- phyaddr=1, 32 ones, write PHYAD 1 REGAD 3 data 0xA5C3 -> one wr_stb, wr_addr=3, wr_data=0xA5C3, regs[63:48]=0xA5C3, mdio_t stays 1.
- After above, read PHYAD 1 REGAD 3 -> rd_stb, mdio_t=0 from TA bit 1 through data bit 0, initiator samples TA=0 and 0xA5C3, mdio_t=1 after last bit.
- Read REGAD 20 with NUM_REGS=16 -> returns 0x0000; write REGAD 20 data 0xFFFF -> wr_stb, regs unchanged.
- Write to PHYAD 2 with data 0xFFFF followed immediately by 31-one preamble + read PHYAD 1 -> no wr_stb, no response (preamble short); same with 32 ones -> valid response.
- Opcode 11 after ST -> frame_err single pulse, mdio_t=1, next valid frame decoded normally; write with TA=11 -> frame_err, no write.
- Assert rst during DATA bit 8 of a read -> mdio_t=1 next clk, regs=0, following read of REGAD 3 returns 0x0000.

Source files
------------

// File: rtl/mdio_responder.sv
// mdio_responder: clause-22 MDIO management responder (PHY side).
// Decodes MDC/MDIO frames oversampled in clk, holds a 16-bit register bank,
// drives read data on MDIO through an output/tristate pair.
// Ports: clk/rst (sync, active-high); phyaddr = own PHY address;
// mdc/mdio_i = async management bus in; mdio_o/mdio_t = drive value and
// release (1 = high-Z); regs = bank, reg n at [16n+15:16n];
// wr_stb/wr_addr/wr_data = completed write; rd_stb = accepted read;
// frame_err = aborted frame.
module mdio_responder #(
  parameter int NUM_REGS = 16,
  parameter int PRE_MIN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               phyaddr,
  input  logic                     mdc,
  input  logic                     mdio_i,
  output logic                     mdio_o,
  output logic                     mdio_t,
  output logic [16*NUM_REGS-1:0]   regs,
  output logic                     wr_stb,
  output logic [4:0]               wr_addr,
  output logic [15:0]              wr_data,
  output logic                     rd_stb,
  output logic                     frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } state_t;

  logic [2:0]            mdc_q;
  logic [1:0]            mdio_q;
  state_t                state_q, state_d;
  logic [5:0]            ones_q, ones_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op0_q, op0_d;
  logic                  rd_q, rd_d;
  logic                  match_q, match_d;
  logic [3:0]            phy_q, phy_d;
  logic [4:0]            reg_q, reg_d;
  logic [15:0]           sh_q, sh_d;
  logic                  mdio_o_q, mdio_o_d;
  logic                  mdio_t_q, mdio_t_d;
  logic [16*NUM_REGS-1:0] regs_q, regs_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  rd_stb_q, rd_stb_d;
  logic                  err_q, err_d;

  logic                  rise;
  logic                  sbit;
  logic [4:0]            regad_nx;
  logic [15:0]           rd_word;
  logic [15:0]           wdata_nx;

  // mdc_q[1] is the synchronized level, mdc_q[2] its delayed copy
  assign rise     = mdc_q[1] & ~mdc_q[2];
  assign sbit     = mdio_q[1];
  assign regad_nx = {reg_q[3:0], sbit};
  assign wdata_nx = {sh_q[14:0], sbit};

  // Addresses beyond the bank match no entry and read back as zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (regad_nx == 5'(i)) rd_word = regs_q[16*i +: 16];
    end
  end

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    cnt_d     = cnt_q;
    op0_d     = op0_q;
    rd_d      = rd_q;
    match_d   = match_q;
    phy_d     = phy_q;
    reg_d     = reg_q;
    sh_d      = sh_q;
    mdio_o_d  = mdio_o_q;
    mdio_t_d  = mdio_t_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_stb_d  = 1'b0;
    err_d     = 1'b0;
    if (rise) begin
      unique case (state_q)
        S_IDLE: begin
          if (sbit) begin
            if (ones_q != 6'd32) ones_d = ones_q + 6'd1;
          end else begin
            // this zero is the first start bit
            if (ones_q >= 6'(PRE_MIN)) state_d = S_ST;
            ones_d = '0;
          end
        end
        S_ST: begin
          if (sbit) begin
            state_d = S_OP;
            cnt_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_OP: begin
          if (cnt_q == 4'd0) begin
            op0_d = sbit;
            cnt_d = 4'd1;
          end else if (op0_q != sbit) begin
            rd_d    = op0_q;
            state_d = S_PHYAD;
            cnt_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_PHYAD: begin
          phy_d = {phy_q[2:0], sbit};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd4) begin
            match_d = ({phy_q, sbit} == phyaddr);
            state_d = S_REGAD;
            cnt_d   = '0;
          end
        end
        S_REGAD: begin
          reg_d = regad_nx;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd4) begin
            state_d = S_TA;
            cnt_d   = '0;
            if (rd_q && match_q) begin
              sh_d     = rd_word;
              rd_stb_d = 1'b1;
            end
          end
        end
        S_TA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            if (rd_q) begin
              if (match_q) begin
                mdio_t_d = 1'b0;
                mdio_o_d = 1'b0;
              end
            end else if (!sbit) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            if (rd_q) begin
              if (match_q) begin
                mdio_o_d = sh_q[15];
                sh_d     = {sh_q[14:0], 1'b0};
              end
            end else if (sbit) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (rd_q) begin
            if (cnt_q == 4'd15) begin
              mdio_t_d = 1'b1;
              mdio_o_d = 1'b1;
              state_d  = S_IDLE;
            end else if (match_q) begin
              mdio_o_d = sh_q[15];
              sh_d     = {sh_q[14:0], 1'b0};
            end
          end else begin
            sh_d = wdata_nx;
            if (cnt_q == 4'd15) begin
              state_d = S_IDLE;
              if (match_q) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = reg_q;
                wr_data_d = wdata_nx;
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (reg_q == 5'(i)) regs_d[16*i +: 16] = wdata_nx;
                end
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q     <= '0;
      mdio_q    <= 2'b11;
      state_q   <= S_IDLE;
      ones_q    <= '0;
      cnt_q     <= '0;
      op0_q     <= 1'b0;
      rd_q      <= 1'b0;
      match_q   <= 1'b0;
      phy_q     <= '0;
      reg_q     <= '0;
      sh_q      <= '0;
      mdio_o_q  <= 1'b1;
      mdio_t_q  <= 1'b1;
      regs_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_stb_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mdc_q     <= {mdc_q[1:0], mdc};
      mdio_q    <= {mdio_q[0], mdio_i};
      state_q   <= state_d;
      ones_q    <= ones_d;
      cnt_q     <= cnt_d;
      op0_q     <= op0_d;
      rd_q      <= rd_d;
      match_q   <= match_d;
      phy_q     <= phy_d;
      reg_q     <= reg_d;
      sh_q      <= sh_d;
      mdio_o_q  <= mdio_o_d;
      mdio_t_q  <= mdio_t_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_stb_q  <= rd_stb_d;
      err_q     <= err_d;
    end
  end

  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;
  assign regs      = regs_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_stb    = rd_stb_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed frames against mdio_responder
// with hand-computed expectations.
module tb_mdio_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   phyaddr;
  logic         mdc;
  logic         mdio_o;
  logic         mdio_t;
  logic [255:0] regs;
  logic         wr_stb;
  logic [4:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         rd_stb;
  logic         frame_err;

  logic         tb_oe;
  logic         tb_val;
  wire          mdio_line = mdio_t ? (tb_oe ? tb_val : 1'b1) : mdio_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_tlow = 0;
  int w0, r0, e0, t0;
  logic [4:0]   lw_addr = '0;
  logic [15:0]  lw_data = '0;
  logic [255:0] exp_regs;
  logic [15:0]  rdat;
  logic         ta_s;

  always #4 clk = ~clk;

  mdio_responder dut (
    .clk(clk),
    .rst(rst),
    .phyaddr(phyaddr),
    .mdc(mdc),
    .mdio_i(mdio_line),
    .mdio_o(mdio_o),
    .mdio_t(mdio_t),
    .regs(regs),
    .wr_stb(wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_stb(rd_stb),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      n_wr++;
      lw_addr = wr_addr;
      lw_data = wr_data;
    end
    if (rd_stb) n_rd++;
    if (frame_err) n_err++;
    if (!mdio_t) n_tlow++;
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    w0 = n_wr;
    r0 = n_rd;
    e0 = n_err;
    t0 = n_tlow;
  endtask

  // one MDC period: low 7 clk, high 9 clk; line sampled just before rise
  task automatic bit_cyc(input logic oe, input logic b, output logic smp);
    @(negedge clk);
    mdc    = 1'b0;
    tb_oe  = oe;
    tb_val = b;
    repeat (7) @(negedge clk);
    smp = mdio_line;
    mdc = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(input int pre, input logic [1:0] op,
                       input logic [4:0] pa, input logic [4:0] ra,
                       input logic [1:0] ta, input logic [15:0] wd,
                       input int rst_bit,
                       output logic [15:0] rd, output logic tas);
    logic s;
    logic drv;
    drv = (op != 2'b10);
    rd  = '0;
    for (int i = 0; i < pre; i++) bit_cyc(1'b1, 1'b1, s);
    bit_cyc(1'b1, 1'b0, s);
    bit_cyc(1'b1, 1'b1, s);
    for (int i = 1; i >= 0; i--) bit_cyc(1'b1, op[i], s);
    for (int i = 4; i >= 0; i--) bit_cyc(1'b1, pa[i], s);
    for (int i = 4; i >= 0; i--) bit_cyc(1'b1, ra[i], s);
    bit_cyc(drv, ta[1], s);
    bit_cyc(drv, ta[0], s);
    tas = s;
    for (int i = 15; i >= 0; i--) begin
      bit_cyc(drv, wd[i], s);
      rd[i] = s;
      if (i == rst_bit) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mdio_t", 256'(mdio_t), 256'(1'b1));
        chk("rst_regs", regs, 256'(0));
        rst = 1'b0;
      end
    end
    tb_oe  = 1'b1;
    tb_val = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    mdc      = 1'b0;
    tb_oe    = 1'b1;
    tb_val   = 1'b1;
    phyaddr  = 5'd1;
    exp_regs = '0;
    repeat (5) @(negedge clk);
    chk("rst_mdio_o", 256'(mdio_o), 256'(1'b1));
    chk("rst_mdio_t", 256'(mdio_t), 256'(1'b1));
    chk("rst_regs", regs, 256'(0));
    chk("rst_strobes", 256'({wr_stb, rd_stb, frame_err}), 256'(0));
    chk("rst_wr_addr", 256'(wr_addr), 256'(0));
    chk("rst_wr_data", 256'(wr_data), 256'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // write reg 3
    snap();
    frame(32, 2'b01, 5'd1, 5'd3, 2'b10, 16'hA5C3, -1, rdat, ta_s);
    exp_regs[63:48] = 16'hA5C3;
    chk("w3_stb", 256'(n_wr - w0), 256'(1));
    chk("w3_addr", 256'(lw_addr), 256'(5'd3));
    chk("w3_data", 256'(lw_data), 256'(16'hA5C3));
    chk("w3_regs", regs, exp_regs);
    chk("w3_tlow", 256'(n_tlow - t0), 256'(0));
    chk("w3_other", 256'((n_rd - r0) + (n_err - e0)), 256'(0));

    // read reg 3: driven for 17 MDC periods of 16 clk
    snap();
    frame(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, -1, rdat, ta_s);
    chk("r3_stb", 256'(n_rd - r0), 256'(1));
    chk("r3_ta", 256'(ta_s), 256'(1'b0));
    chk("r3_data", 256'(rdat), 256'(16'hA5C3));
    chk("r3_tlow", 256'(n_tlow - t0), 256'(272));
    chk("r3_rel", 256'({mdio_t, mdio_o}), 256'(2'b11));

    // out-of-bank read and write
    snap();
    frame(32, 2'b10, 5'd1, 5'd20, 2'b11, 16'h0000, -1, rdat, ta_s);
    chk("r20_stb", 256'(n_rd - r0), 256'(1));
    chk("r20_data", 256'(rdat), 256'(16'h0000));
    snap();
    frame(32, 2'b01, 5'd1, 5'd20, 2'b10, 16'hFFFF, -1, rdat, ta_s);
    chk("w20_stb", 256'(n_wr - w0), 256'(1));
    chk("w20_addr", 256'(lw_addr), 256'(5'd20));
    chk("w20_data", 256'(lw_data), 256'(16'hFFFF));
    chk("w20_regs", regs, exp_regs);

    // foreign PHY, then short preamble, then full preamble
    snap();
    frame(32, 2'b01, 5'd2, 5'd3, 2'b10, 16'hFFFF, -1, rdat, ta_s);
    chk("wp2_stb", 256'(n_wr - w0), 256'(0));
    chk("wp2_regs", regs, exp_regs);
    snap();
    frame(31, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, -1, rdat, ta_s);
    chk("pre31_rd", 256'(n_rd - r0), 256'(0));
    chk("pre31_tlow", 256'(n_tlow - t0), 256'(0));
    chk("pre31_err", 256'(n_err - e0), 256'(0));
    snap();
    frame(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, -1, rdat, ta_s);
    chk("pre32_rd", 256'(n_rd - r0), 256'(1));
    chk("pre32_data", 256'(rdat), 256'(16'hA5C3));

    // bad opcode
    snap();
    frame(32, 2'b11, 5'd1, 5'd3, 2'b10, 16'h1234, -1, rdat, ta_s);
    chk("op11_err", 256'(n_err - e0), 256'(1));
    chk("op11_wr", 256'(n_wr - w0), 256'(0));
    chk("op11_tlow", 256'(n_tlow - t0), 256'(0));
    chk("op11_regs", regs, exp_regs);
    snap();
    frame(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, -1, rdat, ta_s);
    chk("op11_next", 256'(rdat), 256'(16'hA5C3));

    // bad turnaround on write
    snap();
    frame(32, 2'b01, 5'd1, 5'd3, 2'b11, 16'h0F0F, -1, rdat, ta_s);
    chk("ta11_err", 256'(n_err - e0), 256'(1));
    chk("ta11_wr", 256'(n_wr - w0), 256'(0));
    chk("ta11_regs", regs, exp_regs);

    // reset during data bit 8 of a read
    snap();
    frame(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, 8, rdat, ta_s);
    exp_regs = '0;
    chk("rstf_err", 256'(n_err - e0), 256'(0));
    snap();
    frame(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, -1, rdat, ta_s);
    chk("rstf_rd", 256'(n_rd - r0), 256'(1));
    chk("rstf_data", 256'(rdat), 256'(16'h0000));
    chk("rstf_regs", regs, exp_regs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
